// File: rtl/challenge_request.sv
// Initiator-side CHALLENGE engine: sends CHALLENGE, waits for the reply with a timeout, and classifies it.
// Optional retry on timeout is built when CHALLENGE_RETRY_EN is defined.
module challenge_request #(
  parameter int unsigned TIMEOUT_CYCLES     = 1000,
  parameter int unsigned MAX_RETRIES        = 2,
  parameter int unsigned MSG_LEN            = 288,
  parameter logic [7:0]  PROTOCOL_VERSION   = 8'h01,
  parameter logic [7:0]  CHALLENGE_CMD      = 8'h83,
  parameter logic [7:0]  CHALLENGE_AUTH_CMD = 8'h03,
  localparam int unsigned SIZE_OF_HEADER_VARS = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [SIZE_OF_HEADER_VARS-1:0] slot,
  input  logic [MSG_LEN-33:0]            nonce_in,
  output logic                           req_valid,
  input  logic                           req_ready,
  output logic [MSG_LEN-1:0]             req_msg,
  input  logic                           resp_valid,
  input  logic [MSG_LEN-1:0]             resp_msg,
  output logic                           busy,
  output logic                           done,
  output logic                           auth_pass,
  output logic                           auth_fail,
  output logic [7:0]                     error_code,
  output logic [MSG_LEN-33:0]            resp_payload
);

  localparam int unsigned PL_W     = MSG_LEN - 32;
  localparam int unsigned CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned SLOT_LSB = MSG_LEN - 24;
  localparam logic [7:0]  ERROR_CMD = 8'h7F;

  typedef enum logic [2:0] {IDLE, SEND, WAIT_RESP, CHECK, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] to_cnt;
  logic             timed_out;
  logic [7:0]       rsp_ver;
  logic [7:0]       rsp_type;
  logic [7:0]       rsp_p1;
  logic [PL_W-1:0]  rsp_pl;

`ifdef CHALLENGE_RETRY_EN
  localparam int unsigned RC_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  logic [RC_W-1:0] retry_cnt;
`else
  localparam int unsigned unused_max_retries = MAX_RETRIES;
`endif

  // param2 of the reply header carries nothing this engine acts on
  logic [7:0] unused_param2;
  assign unused_param2 = resp_msg[MSG_LEN-25:MSG_LEN-32];

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      to_cnt       <= '0;
      timed_out    <= 1'b0;
      rsp_ver      <= '0;
      rsp_type     <= '0;
      rsp_p1       <= '0;
      rsp_pl       <= '0;
      req_valid    <= 1'b0;
      req_msg      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      auth_pass    <= 1'b0;
      auth_fail    <= 1'b0;
      error_code   <= '0;
      resp_payload <= '0;
`ifdef CHALLENGE_RETRY_EN
      retry_cnt    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            req_msg    <= {PROTOCOL_VERSION, CHALLENGE_CMD, slot, 8'h00, nonce_in};
            auth_pass  <= 1'b0;
            auth_fail  <= 1'b0;
            error_code <= '0;
`ifdef CHALLENGE_RETRY_EN
            retry_cnt  <= '0;
`endif
            req_valid  <= 1'b1;
            busy       <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            to_cnt    <= '0;
            state     <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          // a reply arriving on the last counted cycle beats the timeout
          if (resp_valid) begin
            rsp_ver   <= resp_msg[MSG_LEN-1 -: 8];
            rsp_type  <= resp_msg[MSG_LEN-9 -: 8];
            rsp_p1    <= resp_msg[MSG_LEN-17 -: 8];
            rsp_pl    <= resp_msg[PL_W-1:0];
            timed_out <= 1'b0;
            state     <= CHECK;
          end else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
`ifdef CHALLENGE_RETRY_EN
            if (retry_cnt != RC_W'(MAX_RETRIES)) begin
              retry_cnt <= retry_cnt + RC_W'(1);
              req_valid <= 1'b1;
              state     <= SEND;
            end else begin
              timed_out <= 1'b1;
              state     <= CHECK;
            end
`else
            timed_out <= 1'b1;
            state     <= CHECK;
`endif
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
        end
        CHECK: begin
          done      <= 1'b1;
          state     <= DONE;
          auth_pass <= 1'b0;
          auth_fail <= 1'b1;
          if (timed_out) begin
            error_code <= 8'hFF;
          end else if (rsp_ver != PROTOCOL_VERSION) begin
            error_code <= 8'hFD;
          end else if (rsp_type == ERROR_CMD) begin
            error_code <= (rsp_p1 == 8'h00) ? 8'hFC : rsp_p1;
          end else if (rsp_type != CHALLENGE_AUTH_CMD) begin
            error_code <= 8'hFD;
          end else if (rsp_p1[3:0] != req_msg[SLOT_LSB +: 4]) begin
            error_code <= 8'hFE;
          end else begin
            auth_pass    <= 1'b1;
            auth_fail    <= 1'b0;
            error_code   <= 8'h00;
            resp_payload <= rsp_pl;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_challenge_request.sv
// Scoreboard bench for challenge_request: directed challenges with hand-computed results.
module tb_challenge_request;

  localparam int unsigned MSG_LEN = 64;
  localparam int unsigned TO      = 8;
  localparam int unsigned MR      = 2;
  localparam logic [7:0]  PV      = 8'h01;
  localparam logic [7:0]  CC      = 8'h83;
  localparam logic [7:0]  CA      = 8'h03;

  typedef struct packed {
    logic        pass;
    logic [7:0]  code;
    logic [31:0] pl;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start, req_valid, req_ready, resp_valid;
  logic        busy, done, auth_pass, auth_fail;
  logic [7:0]  slot, error_code;
  logic [31:0] nonce_in, resp_payload;
  logic [63:0] req_msg, resp_msg;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_xfer   = 0;
  exp_t        exp_q[$];
  logic [63:0] exp_req  = '0;

  challenge_request #(
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRIES   (MR),
    .MSG_LEN       (MSG_LEN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .slot        (slot),
    .nonce_in    (nonce_in),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_msg     (req_msg),
    .resp_valid  (resp_valid),
    .resp_msg    (resp_msg),
    .busy        (busy),
    .done        (done),
    .auth_pass   (auth_pass),
    .auth_fail   (auth_fail),
    .error_code  (error_code),
    .resp_payload(resp_payload)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Request monitor: every accepted request must carry the captured message
  always @(negedge clk) begin
    if (!reset && req_valid && req_ready) begin
      n_xfer++;
      check("req_msg", req_msg, exp_req);
    end
  end

  // Result monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no completion");
      end else begin
        e = exp_q.pop_front();
        check("done_pass", 64'(auth_pass), 64'(e.pass));
        check("done_fail", 64'(auth_fail), 64'(!e.pass));
        check("done_code", 64'(error_code), 64'(e.code));
        check("done_busy", 64'(busy), 64'(1'b1));
        if (e.pass) check("done_payload", 64'(resp_payload), 64'(e.pl));
      end
    end
  end

  task automatic expect_result(input logic p, input logic [7:0] c, input logic [31:0] pl);
    exp_t e;
    e.pass = p;
    e.code = c;
    e.pl   = pl;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [7:0] s, input logic [31:0] n);
    exp_req  = {PV, CC, s, 8'h00, n};
    slot     = s;
    nonce_in = n;
    start    = 1'b1;
    cyc();
    start    = 1'b0;
    slot     = 8'hEE;
    nonce_in = 32'hDEAD_BEEF;
    check("start_valid_busy", 64'({req_valid, busy}), 64'(2'b11));
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int k = 0;
    while (!done && k < 200) begin
      cyc();
      k++;
    end
    check(name, 64'(k), 64'(exp_lat));
  endtask

  task automatic send_resp(input logic [31:0] hdr, input logic [31:0] pl);
    resp_valid = 1'b1;
    resp_msg   = {hdr, pl};
    cyc();
    resp_valid = 1'b0;
    resp_msg   = '0;
  endtask

  // One full challenge: optional backpressure, reply after `dly` cycles in WAIT_RESP
  task automatic run_txn(input string name, input logic [7:0] s, input logic [31:0] n,
                         input int bp, input int dly, input logic [31:0] hdr,
                         input logic [31:0] pl, input logic ep, input logic [7:0] ec);
    int x0;
    expect_result(ep, ec, pl);
    do_start(s, n);
    for (int i = 0; i < bp; i++) begin
      check({name, "_bp_valid"}, 64'(req_valid), 64'(1'b1));
      check({name, "_bp_msg"}, req_msg, exp_req);
      cyc();
    end
    x0 = n_xfer;
    req_ready = 1'b1;
    cyc();
    req_ready = 1'b0;
    check({name, "_one_xfer"}, 64'(n_xfer - x0), 64'(1));
    check({name, "_valid_drop"}, 64'(req_valid), 64'(1'b0));
    repeat (dly - 1) cyc();
    send_resp(hdr, pl);
    wait_done({name, "_latency"}, 1);
    cyc();
    check({name, "_held"}, 64'({auth_pass, auth_fail, error_code}), 64'({ep, !ep, ec}));
    check({name, "_idle"}, 64'({busy, done}), 64'(2'b00));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    reset = 1'b1; start = 1'b0; slot = '0; nonce_in = '0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_msg = '0;
    repeat (2) cyc();
    check("rst_ctrl", 64'({req_valid, busy, done, auth_pass, auth_fail}), 64'(0));
    check("rst_data", {error_code, resp_payload}, 64'(0));
    check("rst_req_msg", req_msg, 64'(0));
    reset = 1'b0;
    cyc();

    run_txn("pass",      8'h02, 32'h1234_56A5, 0,  5, {PV, CA, 8'h02, 8'h00}, 32'hCAFE_F00D, 1'b1, 8'h00);
    run_txn("backpress", 8'h01, 32'h0BAD_CAFE, 10, 1, {PV, CA, 8'h01, 8'h00}, 32'h1111_2222, 1'b1, 8'h00);
    run_txn("err_code",  8'h02, 32'h0000_0001, 0,  3, {PV, 8'h7F, 8'h01, 8'h00}, 32'h0, 1'b0, 8'h01);
    run_txn("err_zero",  8'h02, 32'h0000_0002, 0,  2, {PV, 8'h7F, 8'h00, 8'h00}, 32'h0, 1'b0, 8'hFC);
    run_txn("slot_mis",  8'h02, 32'h0000_0003, 0,  2, {PV, CA, 8'h03, 8'h00}, 32'h5555_5555, 1'b0, 8'hFE);
    run_txn("bad_ver",   8'h02, 32'h0000_0004, 0,  2, {8'h02, CA, 8'h02, 8'h00}, 32'h0, 1'b0, 8'hFD);
    run_txn("ver_over_err", 8'h02, 32'h0000_0005, 0, 2, {8'h02, 8'h7F, 8'h01, 8'h00}, 32'h0, 1'b0, 8'hFD);
    run_txn("bad_type",  8'h02, 32'h0000_0006, 0,  2, {PV, 8'h05, 8'h02, 8'h00}, 32'h0, 1'b0, 8'hFD);
    run_txn("slot_nib",  8'h12, 32'hA5A5_0007, 0,  4, {PV, CA, 8'h02, 8'h7E}, 32'h7777_8888, 1'b1, 8'h00);

    // resp_valid while idle is neither latched nor acted on
    send_resp({PV, CA, 8'h02, 8'h00}, 32'hFFFF_0000);
    repeat (3) cyc();
    check("idle_resp_ignored", 64'({busy, done, auth_pass, resp_payload}), 64'({3'b001, 32'h7777_8888}));

    // start while busy does not recapture slot
    expect_result(1'b1, 8'h00, 32'h0102_0304);
    do_start(8'h02, 32'h0000_00A5);
    req_ready = 1'b1; cyc(); req_ready = 1'b0;
    slot = 8'h05; start = 1'b1; cyc(); start = 1'b0;
    check("busy_start_msg", req_msg, exp_req);
    check("busy_start_state", 64'({busy, req_valid}), 64'(2'b10));
    send_resp({PV, CA, 8'h02, 8'h00}, 32'h0102_0304);
    wait_done("busy_start_lat", 1);
    cyc();

    // reply on the exact timeout cycle wins, no re-send
    expect_result(1'b1, 8'h00, 32'h9999_AAAA);
    do_start(8'h03, 32'h0000_0033);
    req_ready = 1'b1; cyc(); req_ready = 1'b0;
    x0 = n_xfer;
    repeat (TO - 1) cyc();
    send_resp({PV, CA, 8'h03, 8'h00}, 32'h9999_AAAA);
    wait_done("edge_resp_lat", 1);
    check("edge_resp_no_resend", 64'(n_xfer - x0), 64'(0));
    cyc();

`ifdef CHALLENGE_RETRY_EN
    // all attempts time out: MR+1 requests, then fail FF
    expect_result(1'b0, 8'hFF, 32'h0);
    x0 = n_xfer;
    do_start(8'h04, 32'h0000_0044);
    req_ready = 1'b1; cyc();
    wait_done("retry_exhaust_lat", (MR + 1) * (TO + 1));
    req_ready = 1'b0;
    check("retry_exhaust_xfers", 64'(n_xfer - x0), 64'(MR + 1));
    cyc();

    // reply on the second attempt passes
    expect_result(1'b1, 8'h00, 32'h2222_3333);
    x0 = n_xfer;
    do_start(8'h04, 32'h0000_0045);
    req_ready = 1'b1; cyc();
    repeat (TO + 1) cyc();
    req_ready = 1'b0;
    repeat (2) cyc();
    send_resp({PV, CA, 8'h04, 8'h00}, 32'h2222_3333);
    wait_done("retry_second_lat", 1);
    check("retry_second_xfers", 64'(n_xfer - x0), 64'(2));
    cyc();
`else
    // single timeout: done TO+1 cycles after WAIT_RESP entry
    expect_result(1'b0, 8'hFF, 32'h0);
    x0 = n_xfer;
    do_start(8'h04, 32'h0000_0044);
    req_ready = 1'b1; cyc(); req_ready = 1'b0;
    wait_done("timeout_lat", TO + 1);
    check("timeout_xfers", 64'(n_xfer - x0), 64'(1));
    cyc();
`endif

    // reset mid-WAIT_RESP discards everything, late reply ignored
    do_start(8'h02, 32'h0000_0055);
    req_ready = 1'b1; cyc(); req_ready = 1'b0;
    repeat (3) cyc();
    reset = 1'b1; cyc(); reset = 1'b0;
    check("rst_wait_ctrl", 64'({req_valid, busy, done, auth_pass, auth_fail}), 64'(0));
    check("rst_wait_data", {error_code, resp_payload}, 64'(0));
    check("rst_wait_req_msg", req_msg, 64'(0));
    send_resp({PV, CA, 8'h02, 8'h00}, 32'h4444_4444);
    repeat (3) cyc();
    check("late_resp_ignored", 64'({busy, done, auth_pass, resp_payload}), 64'(0));

    // reset mid-SEND drops req_valid
    do_start(8'h02, 32'h0000_0066);
    repeat (3) cyc();
    check("send_hold_valid", 64'(req_valid), 64'(1'b1));
    reset = 1'b1; cyc(); reset = 1'b0;
    check("rst_send_ctrl", 64'({req_valid, busy, done}), 64'(0));
    repeat (3) cyc();
    check("rst_send_stays_idle", 64'({req_valid, busy}), 64'(0));

    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
